// File: rtl/tt_um_pc_sequencer.sv
// Microsequencer driving the en/load/oe control pins of an 8-bit loadable PC tile.
// Optional single-step FETCH enabled by defining SEQ_STEP_EN.
module tt_um_pc_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned PC_W  = 8;
  localparam int unsigned CNT_W = 6;

  localparam logic [1:0] OP_NOP  = 2'b00;
  localparam logic [1:0] OP_JMP  = 2'b01;
  localparam logic [1:0] OP_JC   = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_OPADV, S_OPER, S_LOAD, S_ADV, S_HALT
  } state_t;

  state_t             r_state;
  logic [PC_W-1:0]    r_instr;
  logic [PC_W-1:0]    r_target;
  logic [CNT_W-1:0]   r_wait;
  logic [PC_W-1:0]    r_pc;
  logic [PC_W-1:0]    r_uo_out;
  logic               r_pc_oe;
  logic               r_pc_load;
  logic               r_pc_en;
  logic               r_halted;

  state_t             w_next;
  logic [PC_W-1:0]    w_pc_nxt;
  logic               w_cond;
  logic               w_start;
  logic               w_step;
  logic               w_unused;

  assign w_cond  = uio_in[0];
  assign w_start = uio_in[1];

`ifdef SEQ_STEP_EN
  assign w_step   = uio_in[2];
  assign w_unused = &{1'b0, ena, uio_in[7:3], r_instr[5:0]};
`else
  assign w_step   = 1'b1;
  assign w_unused = &{1'b0, ena, uio_in[7:2], r_instr[5:0]};
`endif

  // Next-state rule; OPER only ever sees JMP or JC in the instruction register
  function automatic state_t f_next(input state_t st, input logic [7:0] byte_in,
                                    input logic [1:0] op, input logic [CNT_W-1:0] wait_cnt,
                                    input logic start, input logic step, input logic cond);
    state_t nxt;
    nxt = st;
    case (st)
      S_IDLE:  nxt = start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        if (!step) begin
          nxt = S_FETCH;
        end else begin
          case (byte_in[7:6])
            OP_NOP:  nxt = (byte_in[5:0] == 6'd0) ? S_ADV : S_WAIT;
            OP_JMP:  nxt = S_OPADV;
            OP_JC:   nxt = S_OPADV;
            OP_HALT: nxt = S_HALT;
            default: nxt = S_HALT;
          endcase
        end
      end
      S_WAIT:  nxt = (wait_cnt <= CNT_W'(1)) ? S_ADV : S_WAIT;
      S_OPADV: nxt = S_OPER;
      S_OPER:  nxt = ((op == OP_JMP) || cond) ? S_LOAD : S_ADV;
      S_LOAD:  nxt = S_FETCH;
      S_ADV:   nxt = S_FETCH;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_IDLE;
    endcase
    return nxt;
  endfunction

  assign w_next = f_next(r_state, ui_in, r_instr[7:6], r_wait, w_start, w_step, w_cond);

  // Shadow PC follows the strobes currently on the pins
  assign w_pc_nxt = r_pc_load ? r_target :
                    r_pc_en   ? r_pc + PC_W'(1) : r_pc;

  // State, datapath and Moore strobes registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_instr   <= '0;
      r_target  <= '0;
      r_wait    <= '0;
      r_pc      <= '0;
      r_uo_out  <= '0;
      r_pc_oe   <= 1'b0;
      r_pc_load <= 1'b0;
      r_pc_en   <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_FETCH) && w_step) begin
        r_instr <= ui_in;
        r_wait  <= ui_in[CNT_W-1:0];
      end else if (r_state == S_WAIT) begin
        r_wait <= r_wait - CNT_W'(1);
      end
      if (r_state == S_OPER) begin
        r_target <= ui_in;
      end
      r_pc      <= w_pc_nxt;
      r_uo_out  <= (w_next == S_LOAD) ? ui_in : w_pc_nxt;
      r_pc_oe   <= (w_next == S_FETCH) || (w_next == S_OPER);
      r_pc_load <= (w_next == S_LOAD);
      r_pc_en   <= (w_next == S_OPADV) || (w_next == S_ADV);
      r_halted  <= (w_next == S_HALT);
    end
  end

  assign uo_out  = r_uo_out;
  assign uio_out = {r_pc_oe, r_pc_load, r_pc_en, r_halted, 4'h0};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_pc_sequencer.sv
// Bench for tt_um_pc_sequencer: program ROM + external counter around the DUT,
// instruction-level trace model compared every cycle, plus literal pin checks.
module tb_tt_um_pc_sequencer;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  logic       r_cond;
  logic       r_start;
  logic       r_step;

  logic [7:0] mem [256];
  logic [7:0] ext_pc;

  logic [15:0] exp_q [$];
  logic [15:0] got [64];

  int n_tests;
  int n_fail;

  localparam logic [7:0] F_OE   = 8'h80;
  localparam logic [7:0] F_LOAD = 8'h40;
  localparam logic [7:0] F_EN   = 8'h20;
  localparam logic [7:0] F_HALT = 8'h10;

  tt_um_pc_sequencer dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uio_in  (uio_in),
    .uo_out  (uo_out),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign uio_in = {5'b0, r_step, r_start, r_cond};

  // External loadable counter sharing rst_n, and the ROM it addresses
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ext_pc <= 8'h00;
    else if (uio_out[6]) ext_pc <= uo_out;
    else if (uio_out[5]) ext_pc <= ext_pc + 8'd1;
  end

  always @* ui_in = mem[ext_pc];

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, req);
    end
  endtask

  task automatic push(input logic [7:0] pc, input logic [7:0] flags);
    exp_q.push_back({pc, flags});
  endtask

  // Instruction-level model: expands each instruction into its per-cycle pin values
  task automatic build_trace(input int ncyc, input logic cond_v);
    logic [7:0] pc, ins, tgt;
    pc = 8'h00;
    exp_q.delete();
    while (exp_q.size() < ncyc) begin
      ins = mem[pc];
      push(pc, F_OE);
      case (ins[7:6])
        2'b00: begin
          for (int k = 0; k < int'(ins[5:0]); k++) push(pc, 8'h00);
          push(pc, F_EN);
          pc = pc + 8'd1;
        end
        2'b11: begin
          while (exp_q.size() < ncyc) push(pc, F_HALT);
        end
        default: begin
          push(pc, F_EN);
          pc = pc + 8'd1;
          push(pc, F_OE);
          tgt = mem[pc];
          if (ins[7:6] == 2'b01 || cond_v) begin
            push(tgt, F_LOAD);
            pc = tgt;
          end else begin
            push(pc, F_EN);
            pc = pc + 8'd1;
          end
        end
      endcase
    end
  endtask

  task automatic clear_mem();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
  endtask

  // Reset, start, then compare ncyc cycles against the model trace
  task automatic run_prog(input string name, input int ncyc, input logic cond_v,
                          input bit toggle_start);
    logic [15:0] e;
    r_cond  = cond_v;
    r_start = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    check8({name, "_rst_uo"},  uo_out,  8'h00);
    check8({name, "_rst_uio"}, uio_out, 8'h00);
    check8({name, "_rst_oe"},  uio_oe,  8'hF0);
    build_trace(ncyc, cond_v);
    rst_n   = 1'b1;
    r_start = 1'b1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      e = exp_q[i];
      got[i] = {uo_out, uio_out};
      check8($sformatf("%s_c%0d_uo", name, i),  uo_out,  e[15:8]);
      check8($sformatf("%s_c%0d_uio", name, i), uio_out, e[7:0]);
      if (toggle_start) r_start = ~r_start;
    end
    r_start = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ena     = 1'b1;
    r_cond  = 1'b0;
    r_start = 1'b0;
    r_step  = 1'b1;
    rst_n   = 1'b0;
    clear_mem();
    #1;
    check8("async_rst_uo",  uo_out,  8'h00);
    check8("async_rst_uio", uio_out, 8'h00);

    // All-NOP-0 memory: FETCH/ADV alternate, PC counts up
    clear_mem();
    run_prog("nop0", 10, 1'b0, 1'b0);
    check8("nop0_pin_c1_en", got[1][7:0], 8'h20);
    check8("nop0_pin_c4_uo", got[4][15:8], 8'h02);
    check8("nop0_pin_c8_oe", got[8][7:0], 8'h80);

    // JMP 0x10
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'h10;
    run_prog("jmp", 8, 1'b0, 1'b0);
    check8("jmp_pin_c1_en",   got[1][7:0],  8'h20);
    check8("jmp_pin_c3_load", got[3][7:0],  8'h40);
    check8("jmp_pin_c3_tgt",  got[3][15:8], 8'h10);
    check8("jmp_pin_c4_pc",   got[4][15:8], 8'h10);

    // JC not taken / taken
    clear_mem();
    mem[0] = 8'h80; mem[1] = 8'h20;
    run_prog("jc0", 8, 1'b0, 1'b0);
    check8("jc0_pin_c3_en", got[3][7:0],  8'h20);
    check8("jc0_pin_c4_pc", got[4][15:8], 8'h02);
    run_prog("jc1", 8, 1'b1, 1'b0);
    check8("jc1_pin_c3_load", got[3][7:0],  8'h40);
    check8("jc1_pin_c3_tgt",  got[3][15:8], 8'h20);

    // NOP 3, then reset mid-WAIT aborts at once
    clear_mem();
    mem[0] = 8'h03;
    run_prog("nop3a", 3, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check8("midwait_rst_uo",  uo_out,  8'h00);
    check8("midwait_rst_uio", uio_out, 8'h00);
    run_prog("nop3", 12, 1'b0, 1'b0);
    check8("nop3_pin_c3_idle", got[3][7:0],  8'h00);
    check8("nop3_pin_c4_en",   got[4][7:0],  8'h20);
    check8("nop3_pin_c5_pc",   got[5][15:8], 8'h01);

    // HALT ignores start toggling
    clear_mem();
    mem[0] = 8'hC0;
    run_prog("halt", 24, 1'b0, 1'b1);
    check8("halt_pin_c1", got[1][7:0],  8'h10);
    check8("halt_pin_c23", got[23][7:0], 8'h10);

    // Jump to 0xFF holding NOP 0: shadow PC wraps
    clear_mem();
    mem[0] = 8'h40; mem[1] = 8'hFF;
    run_prog("wrap", 12, 1'b0, 1'b0);
    check8("wrap_pin_c4_pc", got[4][15:8], 8'hFF);
    check8("wrap_pin_c5_en", got[5][7:0],  8'h20);
    check8("wrap_pin_c6_pc", got[6][15:8], 8'h00);

`ifdef SEQ_STEP_EN
    // FETCH holds with pc_oe until step is seen
    clear_mem();
    r_step  = 1'b0;
    rst_n   = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    r_start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check8($sformatf("step_hold%0d_uio", i), uio_out, 8'h80);
      check8($sformatf("step_hold%0d_uo", i),  uo_out,  8'h00);
    end
    r_step = 1'b1;
    @(negedge clk);
    check8("step_adv_uio", uio_out, 8'h20);
    @(negedge clk);
    check8("step_next_uo", uo_out, 8'h01);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_pc_sequencer.md
# tt_um_pc_sequencer

Microsequencer that drives the control side of the team's 8-bit loadable program counter: it reads instruction bytes from external program memory, then issues `en`/`load`/`oe` strobes and load targets to the counter. It also keeps a shadow copy of the PC so the address in flight is observable. It is a standalone TinyTapeout top that wires pin-to-pin to the counter tile and a program ROM.

## Interface
Parameters: none.
- `clk`  input  1  clock
- `rst_n`  input  1  reset, asynchronous, active-low
- `ena`  input  1  always 1 when powered; ignored
- `ui_in`  input  8  instruction/operand byte from program memory (addressed by the counter)
- `uio_in`  input  8  [0] `cond` (branch condition), [1] `start` (level), [2] `step` (only with `SEQ_STEP_EN`), [7:3] unused
- `uo_out`  output  8  `pc_load` high: load target; otherwise: shadow PC
- `uio_out`  output  8  [7] `pc_oe`, [6] `pc_load`, [5] `pc_en`, [4] `halted`, [3:0] = 0
- `uio_oe`  output  8  constant 8'hF0

## Operation
- Instruction byte: [7:6] opcode, [5:0] `n`.
  - 00 NOP n: wait n cycles, then advance.
  - 01 JMP: the operand byte at PC+1 is the target.
  - 10 JC: jump to the operand if `cond` = 1, else skip the operand.
  - 11 HALT.
- States, with outputs decoded from the state only (Moore):
  - IDLE: all strobes low. Moves to FETCH when `start` = 1; `start` is ignored in every other state.
  - FETCH: `pc_oe` = 1. Samples `ui_in` into the instruction register on the exiting edge.
    - NOP with n = 0: go to ADV.
    - NOP with n > 0: load the wait counter with n, go to WAIT.
    - JMP or JC: go to OPADV.
    - HALT: go to HALT.
  - WAIT: no strobes. Decrements the wait counter each cycle; goes to ADV on the cycle it reaches 0, so WAIT lasts exactly n cycles.
  - OPADV: `pc_en` = 1, then go to OPER.
  - OPER: `pc_oe` = 1. Samples `ui_in` into the target register and samples `cond` in this cycle.
    - JMP, or JC with `cond` = 1: go to LOAD.
    - Otherwise: go to ADV.
  - LOAD: `pc_load` = 1, `uo_out` = target, then go to FETCH.
  - ADV: `pc_en` = 1, then go to FETCH.
  - HALT: `halted` = 1, no strobes. Exits only via `rst_n`.
- Shadow PC (8-bit):
  - +1 on every cycle where `pc_en` = 1, wrapping 8'hFF to 8'h00.
  - Set to target on every cycle where `pc_load` = 1.
  - Mirrors the external counter exactly when both share `rst_n`.
- At most one of `pc_en`/`pc_load` is high in any cycle. `pc_oe` is never high together with either.
- Unused inputs (`ena`, `uio_in[7:3]`, and `uio_in[2]` without the macro) are collected into an unused wire.

## Timing
- Reset (async assert): state IDLE, shadow PC 8'h00, instruction/target/wait registers 0.
  - `uo_out` = 8'h00, `uio_out` = 8'h00, `uio_oe` = 8'hF0.
  - Deassertion is taken on the next rising `clk`.
- Reset mid-instruction (any state) aborts immediately. There is no partial strobe after the reset edge.
- Cycles per instruction, FETCH through the strobe that completes it:
  - NOP 0: 2.
  - NOP n: 2+n.
  - JMP: 4.
  - JC taken: 4.
  - JC not taken: 4, with two `pc_en` pulses.
- Memory data on `ui_in` must be valid in the FETCH/OPER cycle. It is sampled at the end of that cycle, one cycle after the counter presents the address.
- The first FETCH occurs the cycle after `start` is seen high in IDLE.

## Configuration
- `SEQ_STEP_EN` defined: single-step mode.
  - FETCH holds (with `pc_oe` = 1) until a cycle with `uio_in[2]` = 1.
  - The instruction is sampled on that cycle's edge.
  - All other states are unaffected.
- Not defined: FETCH always lasts one cycle and `uio_in[2]` is unused.

## Test plan
- Reset, memory all 8'h00, `start` = 1 → FETCH then ADV. `pc_en` pulses every 2nd cycle, `uo_out` counts 0,1,2,…
- mem[0] = 8'h40, mem[1] = 8'h10 → `pc_en` in cycle 2. In cycle 4, `pc_load` = 1 with `uo_out` = 8'h10. The next FETCH reads address 8'h10.
- mem[0] = 8'h80, mem[1] = 8'h20:
  - `cond` = 0 → two `pc_en` pulses, no `pc_load`, next FETCH at address 2.
  - `cond` = 1 → `pc_load` with 8'h20.
- mem[0] = 8'h03 → 3 idle cycles after FETCH, then `pc_en`. Assert `rst_n` low during WAIT → outputs 8'h00/8'h00 immediately, and the sequencer restarts from IDLE.
- mem[0] = 8'hC0 → `halted` = 1 from the cycle after FETCH. No strobes for 20 cycles despite `start` toggling.
- Jump to 8'hFF holding a NOP 0 → `pc_en` wraps the shadow PC to 8'h00. With `SEQ_STEP_EN`, FETCH holds until `step` = 1.
